// File: rtl/stim_seq_pkg.sv
// Shared types and default parameter values for the stimulus sequencer.
package stim_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int unsigned DEF_INPUT_LEN  = 7;
    localparam int unsigned DEF_OUTPUT_LEN = 19;
    localparam int unsigned DEF_DEPTH      = 10000000;
    localparam int unsigned DEF_ADDR_W     = 24;

endpackage

// File: rtl/stim_misr.sv
// Rotate-and-xor signature register over the DUT response.
module stim_misr #(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    // Clear on reset or new playback, otherwise fold in the response when enabled.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ din;
        end
    end

endmodule

// File: rtl/stim_sequencer.sv
// Plays packed {rst, data} vectors from a stimulus memory onto a DUT.
// Optional response signature enabled by defining STIM_SIG_MISR_EN.
module stim_sequencer
    import stim_seq_pkg::*;
#(
    parameter int unsigned INPUT_LEN  = DEF_INPUT_LEN,
    parameter int unsigned OUTPUT_LEN = DEF_OUTPUT_LEN,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     num_vec,
    input  logic                  pause,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [INPUT_LEN:0]    mem_data,
    output logic                  dut_rst,
    output logic [INPUT_LEN-1:0]  dut_in,
    input  logic [OUTPUT_LEN-1:0] dut_out,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     vec_cnt
`ifdef STIM_SIG_MISR_EN
    ,
    output logic [OUTPUT_LEN-1:0] signature
`endif
);

    // ADDR_W must be wide enough that DEPTH fits in the length register.
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    state_t              state;
    state_t              state_d;
    logic                mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W-1:0]   next_addr_d;
    logic [ADDR_W-1:0]   length;
    logic [ADDR_W-1:0]   length_d;
    logic                done_d;
    logic                busy_d;
    logic                accept;
    logic                rd_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next values of the read-side registers.
    always_comb begin
        state_d     = state;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr;
        next_addr_d = next_addr;
        length_d    = length;
        done_d      = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (num_vec != '0) begin
                        state_d     = RUN;
                        length_d    = (num_vec > DEPTH_A) ? DEPTH_A : num_vec;
                        mem_addr_d  = '0;
                        next_addr_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Leave once the last address is on the bus; otherwise issue the next one.
                if (mem_rd && (mem_addr == length - ONE_A)) begin
                    state_d = FLUSH;
                end else if (!pause && (next_addr != length)) begin
                    mem_rd_d    = 1'b1;
                    mem_addr_d  = next_addr;
                    next_addr_d = next_addr + ONE_A;
                end
            end
            FLUSH: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Read strobe, address, status and the one-deep read-return tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            next_addr <= '0;
            length    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            mem_rd    <= mem_rd_d;
            mem_addr  <= mem_addr_d;
            next_addr <= next_addr_d;
            length    <= length_d;
            busy      <= busy_d;
            done      <= done_d;
            rd_q      <= mem_rd;
        end
    end

    // Apply returned memory words to the DUT and count them.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_rst <= 1'b1;
            dut_in  <= '0;
            vec_cnt <= '0;
        end else begin
            if (rd_q) begin
                {dut_rst, dut_in} <= mem_data;
            end
            if (accept) begin
                vec_cnt <= '0;
            end else if (rd_q) begin
                vec_cnt <= vec_cnt + ONE_A;
            end
        end
    end

`ifdef STIM_SIG_MISR_EN
    logic apply_q;

    // The DUT reacts to an applied vector one cycle later; sample its response then.
    always_ff @(posedge clk) begin
        if (rst) begin
            apply_q <= 1'b0;
        end else begin
            apply_q <= rd_q;
        end
    end

    stim_misr #(
        .WIDTH (OUTPUT_LEN)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (apply_q),
        .din (dut_out),
        .sig (signature)
    );
`else
    logic unused_dut_out;
    assign unused_dut_out = ^dut_out;
`endif

endmodule

// File: tb/tb_stim_sequencer.sv
// Self-checking bench for stim_sequencer (small DEPTH to exercise clamping).
module tb_stim_sequencer;

    localparam int unsigned IL    = 7;
    localparam int unsigned OL    = 19;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] num_vec;
    logic          pause;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [IL:0]   mem_data;
    logic          dut_rst;
    logic [IL-1:0] dut_in;
    logic [OL-1:0] dut_out;
    logic          busy;
    logic          done;
    logic [AW-1:0] vec_cnt;
`ifdef STIM_SIG_MISR_EN
    logic [OL-1:0] signature;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:15];

    stim_sequencer #(
        .INPUT_LEN  (IL),
        .OUTPUT_LEN (OL),
        .DEPTH      (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_vec  (num_vec),
        .pause    (pause),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .dut_rst  (dut_rst),
        .dut_in   (dut_in),
        .dut_out  (dut_out),
        .busy     (busy),
        .done     (done),
        .vec_cnt  (vec_cnt)
`ifdef STIM_SIG_MISR_EN
        ,
        .signature (signature)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous memory: data valid the cycle after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr[3:0]];
        else        mem_data <= 8'($urandom);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One playback: n requested, pause held for pm edges starting at edge pa (0 = none).
    task automatic play(input int n, input int pa, input int pm);
        int         len, p_eff, exp_done, done_k, done_cnt, busy_cnt, first_k, cnt_at_done;
        int         rdq[$];
        logic [7:0] appq[$];
        logic [AW-1:0] prev_cnt;
        bit         fin;
        logic [OL-1:0] sig_model;
        logic [OL-1:0] sig_seen;
        logic [OL-1:0] sig_first;

        len       = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        p_eff     = (pa >= 1 && pa <= len) ? pm : 0;
        exp_done  = (len == 0) ? 0 : len + 2 + p_eff;
        done_k    = -1;
        first_k   = -1;
        done_cnt  = 0;
        busy_cnt  = 0;
        cnt_at_done = -1;
        fin       = 1'b0;
        sig_seen  = '0;
        sig_first = '0;

        start   = 1'b1;
        num_vec = AW'(n);
        tick();
        start   = 1'b0;
        num_vec = AW'($urandom_range(1, 15));
        prev_cnt = vec_cnt;
        check("vec_cnt_cleared", 64'(vec_cnt), 64'(0));
`ifdef STIM_SIG_MISR_EN
        sig_first = signature;
`endif
        for (int k = 0; k < 80 && !fin; k++) begin
            if (k > 0) tick();
            if (mem_rd) rdq.push_back(int'(mem_addr));
            if (vec_cnt != prev_cnt) begin
                appq.push_back({dut_rst, dut_in});
                if (first_k < 0) first_k = k;
                prev_cnt = vec_cnt;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    cnt_at_done = int'(vec_cnt);
                end
            end
`ifdef STIM_SIG_MISR_EN
            if (done_k >= 0 && k == done_k + 1) sig_seen = signature;
`endif
            start   = (k == 1) && busy;
            num_vec = AW'($urandom_range(1, 15));
            pause   = (pa != 0) && (k + 1 >= pa) && (k + 1 < pa + pm);
            if (done_k >= 0 && k == done_k + 2) fin = 1'b1;
        end
        start = 1'b0;
        pause = 1'b0;

        check("completed", 64'(fin), 64'(1));
        check("done_cycle", 64'(done_k), 64'(exp_done));
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("vec_cnt_at_done", 64'(cnt_at_done), 64'(len));
        check("busy_cycles", 64'(busy_cnt), 64'((len == 0) ? 0 : len + 2 + p_eff));
        check("read_count", 64'(rdq.size()), 64'(len));
        check("apply_count", 64'(appq.size()), 64'(len));
        for (int i = 0; i < len && i < rdq.size(); i++)
            check("read_addr", 64'(rdq[i]), 64'(i));
        for (int i = 0; i < len && i < appq.size(); i++)
            check("applied_vec", 64'(appq[i]), 64'(mem[i]));
        if (len > 0) begin
            check("first_apply", 64'(first_k), 64'(3 + ((pa == 1) ? pm : 0)));
            check("hold_last", 64'({dut_rst, dut_in}), 64'(mem[len - 1]));
        end
        check("idle_busy", 64'(busy), 64'(0));
        check("final_vec_cnt", 64'(vec_cnt), 64'(len));
`ifdef STIM_SIG_MISR_EN
        sig_model = '0;
        for (int i = 0; i < len; i++) sig_model = {sig_model[OL-2:0], sig_model[OL-1]} ^ dut_out;
        check("sig_cleared", 64'(sig_first), 64'(0));
        check("signature", 64'(sig_seen), 64'(sig_model));
`else
        sig_model = sig_seen ^ sig_first;
`endif
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pause   = 1'b0;
        num_vec = '0;
        dut_out = 19'h1;
        for (int j = 0; j < 16; j++) mem[j] = 8'($urandom);

        // Power-on reset values.
        tick();
        tick();
        check("rst_mem_rd", 64'(mem_rd), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_dut_rst", 64'(dut_rst), 64'(1));
        check("rst_dut_in", 64'(dut_in), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_vec_cnt", 64'(vec_cnt), 64'(0));
        rst = 1'b0;
        tick();

        // Basic four-vector playback.
        mem[0] = 8'h80; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h7F;
        play(4, 0, 0);
        tick();

        // Zero-length request.
        play(0, 0, 0);
        tick();

        // Pause for three cycles after the second read.
        play(6, 3, 3);
        tick();

        // Request longer than DEPTH is clamped.
        for (int j = 0; j < 16; j++) mem[j] = 8'($urandom);
        play(20, 0, 0);
        tick();

        // Reset in the middle of a run.
        start   = 1'b1;
        num_vec = AW'(6);
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        tick();
        check("midrst_mem_rd", 64'(mem_rd), 64'(0));
        check("midrst_mem_addr", 64'(mem_addr), 64'(0));
        check("midrst_dut_rst", 64'(dut_rst), 64'(1));
        check("midrst_dut_in", 64'(dut_in), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_vec_cnt", 64'(vec_cnt), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_quiet", 64'({done, mem_rd, busy}), 64'(0));
        end
        play(4, 0, 0);
        tick();

        // Randomised playbacks.
        for (int it = 0; it < 12; it++) begin
            int n, pa, pm;
            for (int j = 0; j < 16; j++) mem[j] = 8'($urandom);
            n  = int'($urandom_range(0, 12));
            pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n + 2)) : 0;
            pm = int'($urandom_range(1, 4));
            play(n, pa, pm);
            repeat ($urandom_range(1, 3)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
